bit_serial_addsub: RTL and testbench

//   Multi-cycle WIDTH-bit adder/subtractor processing one bit per clock, LSB first,

---
 rtl/bit_serial_addsub.sv | 145 ++++++++++++++
 tb/tb_bit_serial_addsub.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first.
// Define OVERFLOW_FLAG_EN to build the signed overflow flag; otherwise ovf is 0.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             s_bit;
  logic             c_nxt;
  logic             last;

`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell working on the current LSBs
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) |
                 (a_q[0] & c_q) |
                 (b_q[0] & c_q);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        c_d   = c_nxt;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_q >> 1;
        res_d[WIDTH-1] = s_bit;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Results are published only on DONE entry
          sum_d   = res_d;
          cout_d  = c_nxt;
`ifdef OVERFLOW_FLAG_EN
          // Carry into MSB vs carry out of MSB
          ovf_d   = c_q ^ c_nxt;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // Overflow flag register, captured with sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub (WIDTH=8).
// Vector table, random ops vs arithmetic model, busy/reset corner cases.
module tb_bit_serial_addsub;

  localparam int W = 8;

`ifdef OVERFLOW_FLAG_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic
  task automatic model(input logic s,
                       input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       output logic [W-1:0] es,
                       output logic ec,
                       output logic eo);
    int ua, ub, sa, sb, r, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (s) begin
      r  = ua - ub;
      ec = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      ec = (r > 255);
      sr = sa + sb;
    end
    es = W'(r);
    eo = OVF_ON & ((sr > 127) || (sr < -128));
  endtask

  // One full operation; samples on negedges, k = edges after accept
  task automatic run_op(input logic s,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input bit poke,
                        output logic [W-1:0] rs,
                        output logic rc,
                        output logic ro);
    int lat;
    int ndone;
    logic [W-1:0] held;
    lat   = -1;
    ndone = 0;
    rs    = 'x;
    rc    = 1'bx;
    ro    = 1'bx;
    held  = sum;
    chk("ready_before", 32'(ready), 32'd1);
    sub   = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sub   = ~s;
    a     = W'($urandom);
    b     = W'($urandom);
    chk("busy_run", {30'd0, busy, ready}, 32'd2);
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          rs  = sum;
          rc  = cout;
          ro  = ovf;
        end
      end else if (lat < 0 && k < W) begin
        if (sum !== held) begin
          chk("sum_held_run", 32'(sum), 32'(held));
        end
      end
      start = poke && (k == 2 || k == W);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(W));
    chk("done_count", 32'(ndone), 32'd1);
    chk("ready_after", 32'(ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] gs, es;
    logic gc, go, ec, eo;
    int nd;

    vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, OVF_ON};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, OVF_ON};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(cout),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b0, gs, gc, go);
      chk($sformatf("vec%0d_sum", i),  32'(gs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(gc), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i),  32'(go), 32'(vecs[i].ovf));
    end

    // Random ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic rsub;
      logic [W-1:0] ra, rb;
      rsub = 1'($urandom);
      ra   = W'($urandom);
      rb   = W'($urandom);
      model(rsub, ra, rb, es, ec, eo);
      run_op(rsub, ra, rb, 1'b0, gs, gc, go);
      chk($sformatf("rnd%0d_sum", i),  32'(gs), 32'(es));
      chk($sformatf("rnd%0d_cout", i), 32'(gc), 32'(ec));
      chk($sformatf("rnd%0d_ovf", i),  32'(go), 32'(eo));
    end

    // start pulsed during RUN and DONE is ignored
    model(1'b0, 8'h3C, 8'h55, es, ec, eo);
    run_op(1'b0, 8'h3C, 8'h55, 1'b1, gs, gc, go);
    chk("poke_sum",  32'(gs), 32'(es));
    chk("poke_cout", 32'(gc), 32'(ec));

    // Reset in the middle of RUN aborts without done
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, gs, gc, go);
    chk("pre_abort_sum", 32'(gs), 32'h10);
    sub   = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_sum",   32'(sum),   32'd0);
    chk("abort_cout",  32'(cout),  32'd0);
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_idle", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
